// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg
// Shared types and constants for the ROM controller.
// Contents:
//   KmacIfTimeoutDefault - default cycle budget for the KMAC digest response
//   KmacIfWordW          - width of one ROM word / KMAC message beat
//   kmac_if_state_e      - sparse state encoding of the KMAC adapter FSM
//   kmac_if_entry_t      - one skid FIFO entry, {data, last}
package rom_ctrl_pkg;

    localparam int unsigned KmacIfTimeoutDefault = 4096;
    localparam int unsigned KmacIfWordW          = 64;

    // Every pair of codes differs in at least three bits, so a single or
    // double bit flip in the state register lands on an invalid code that
    // the FSM maps to Error.
    typedef enum logic [5:0] {
        KmacIfStream     = 6'b000111,
        KmacIfWaitDigest = 6'b011000,
        KmacIfDone       = 6'b101010,
        KmacIfError      = 6'b110101
    } kmac_if_state_e;

    typedef struct packed {
        logic [KmacIfWordW-1:0] data;
        logic                   last;
    } kmac_if_entry_t;

endpackage

// File: rtl/rom_ctrl_kmac_skid.sv
// rom_ctrl_kmac_skid
// Two-entry FIFO that decouples the ROM checker from KMAC back-pressure.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   push_i         write push_entry_i (ignored when full)
//   push_entry_i   {data, last} to store
//   pop_i          drop the head entry (ignored when empty)
//   flush_i        discard all entries; wins over push and pop
//   head_o         oldest stored entry
//   full_o         both entries occupied
//   empty_o        no entry stored
module rom_ctrl_kmac_skid
    import rom_ctrl_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  kmac_if_entry_t push_entry_i,
    input  logic           pop_i,
    input  logic           flush_i,
    output kmac_if_entry_t head_o,
    output logic           full_o,
    output logic           empty_o
);

    kmac_if_entry_t mem_q [2];
    kmac_if_entry_t mem_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     count_q, count_d;
    logic           do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer/count update; a simultaneous push and pop leaves the count
    // unchanged while both pointers advance.
    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rom_ctrl_kmac_if.sv
// rom_ctrl_kmac_if
// Adapter between the ROM checker FSM and the KMAC application port.
// ROM words are buffered in a 2-entry skid FIFO and forwarded to KMAC with
// last/strobe framing; the two digest shares are recombined into digest_o
// and a single done/error indication is returned to the checker.
// Optional feature macro: ROM_CTRL_KMAC_IF_TIMEOUT_EN adds a response
// timeout counter; without it WaitDigest waits indefinitely.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rom_vld_i/rom_rdy_o          ROM word handshake
//   rom_data_i, rom_last_i       ROM word and end-of-region marker
//   kmac_valid_o/kmac_ready_i    KMAC message beat handshake
//   kmac_data_o/strb_o/last_o    KMAC message beat
//   kmac_rsp_done_i/error_i      KMAC digest response strobe and error
//   kmac_rsp_share0_i/share1_i   digest shares
//   done_o                       one-cycle pulse on entry to Done or Error
//   err_o                        high while in Error
//   digest_o                     recombined digest, held while in Done
module rom_ctrl_kmac_if
    import rom_ctrl_pkg::*;
#(
    parameter int unsigned DigestWords   = 8,
    parameter int unsigned TimeoutCycles = KmacIfTimeoutDefault
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rom_vld_i,
    output logic                      rom_rdy_o,
    input  logic [63:0]               rom_data_i,
    input  logic                      rom_last_i,
    output logic                      kmac_valid_o,
    input  logic                      kmac_ready_i,
    output logic [63:0]               kmac_data_o,
    output logic [7:0]                kmac_strb_o,
    output logic                      kmac_last_o,
    input  logic                      kmac_rsp_done_i,
    input  logic                      kmac_rsp_error_i,
    input  logic [DigestWords*64-1:0] kmac_rsp_share0_i,
    input  logic [DigestWords*64-1:0] kmac_rsp_share1_i,
    output logic                      done_o,
    output logic                      err_o,
    output logic [DigestWords*64-1:0] digest_o
);

    localparam int unsigned DigestW = DigestWords * 64;

    kmac_if_state_e     state_q, state_d;
    logic               last_pushed_q, last_pushed_d;
    logic               done_q, done_d;
    logic [DigestW-1:0] digest_q, digest_d;

    logic               fifo_push, fifo_pop, fifo_flush;
    logic               fifo_full, fifo_empty, fifo_valid;
    kmac_if_entry_t     fifo_head, push_entry;
    logic               proto_err, timeout;

    rom_ctrl_kmac_skid u_skid (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .flush_i      (fifo_flush),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign fifo_valid = ~fifo_empty;

    // A response outside WaitDigest, or a new ROM word once the frame has
    // been closed, means the two sides have lost step with each other.
    assign proto_err = (kmac_rsp_done_i & (state_q != KmacIfWaitDigest)) |
                       (rom_vld_i & ((state_q == KmacIfWaitDigest) |
                                     (state_q == KmacIfDone)));

`ifdef ROM_CTRL_KMAC_IF_TIMEOUT_EN
    localparam int unsigned    TmoW    = $clog2(TimeoutCycles);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside WaitDigest so it starts from zero on entry,
    // then counts up and sticks at its final value.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != KmacIfWaitDigest) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TmoLast) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout = (state_q == KmacIfWaitDigest) & (tmo_cnt_q == TmoLast);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= KmacIfStream;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; protocol errors and timeouts take priority over a
    // good response arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            KmacIfStream: begin
                if (proto_err) begin
                    state_d = KmacIfError;
                end else if (fifo_valid & kmac_ready_i & fifo_head.last) begin
                    state_d = KmacIfWaitDigest;
                end
            end
            KmacIfWaitDigest: begin
                if (proto_err | timeout | (kmac_rsp_done_i & kmac_rsp_error_i)) begin
                    state_d = KmacIfError;
                end else if (kmac_rsp_done_i) begin
                    state_d = KmacIfDone;
                end
            end
            KmacIfDone: begin
                if (proto_err) begin
                    state_d = KmacIfError;
                end
            end
            KmacIfError: state_d = KmacIfError;
            default:     state_d = KmacIfError;
        endcase
    end

    // Output logic. rom_rdy_o depends only on registered state so that
    // KMAC back-pressure never reaches the checker combinationally.
    always_comb begin
        rom_rdy_o    = (state_q == KmacIfStream) & ~fifo_full & ~last_pushed_q & ~rst_i;
        kmac_valid_o = fifo_valid;
        kmac_data_o  = fifo_valid ? fifo_head.data : 64'd0;
        kmac_last_o  = fifo_valid & fifo_head.last;
        kmac_strb_o  = {8{fifo_valid}};
        done_o       = done_q;
        err_o        = (state_q == KmacIfError);
        digest_o     = digest_q;
    end

    // Datapath next values. done_o only pulses when leaving the active
    // states, so a later Done to Error move cannot produce a second pulse.
    always_comb begin
        fifo_push     = rom_vld_i & rom_rdy_o;
        fifo_pop      = fifo_valid & kmac_ready_i;
        fifo_flush    = (state_d == KmacIfError);
        push_entry    = '{data: rom_data_i, last: rom_last_i};
        last_pushed_d = last_pushed_q | (fifo_push & rom_last_i);
        done_d        = ((state_q == KmacIfStream) | (state_q == KmacIfWaitDigest)) &
                        ((state_d == KmacIfDone) | (state_d == KmacIfError));
        digest_d      = digest_q;
        if (state_d == KmacIfError) begin
            digest_d = '0;
        end else if ((state_q == KmacIfWaitDigest) & (state_d == KmacIfDone)) begin
            digest_d = kmac_rsp_share0_i ^ kmac_rsp_share1_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_pushed_q <= 1'b0;
            done_q        <= 1'b0;
            digest_q      <= '0;
        end else begin
            last_pushed_q <= last_pushed_d;
            done_q        <= done_d;
            digest_q      <= digest_d;
        end
    end

endmodule
